// File: rtl/mmio_uart_pkg.sv
// Shared constants for the memory-mapped UART transmitter: register offsets,
// STATUS bit layout and serialiser state encodings.
package mmio_uart_pkg;

    localparam logic [3:0] TXDATA_OFF = 4'h0;
    localparam logic [3:0] STATUS_OFF = 4'h8;

    localparam int ST_FULL   = 0;
    localparam int ST_EMPTY  = 1;
    localparam int ST_BUSY   = 2;
    localparam int ST_OVF    = 3;
    localparam int ST_CNT_LO = 4;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    // The STATUS count field is only four bits wide, so deeper FIFOs report 15.
    function automatic logic [3:0] sat_count4(input logic [31:0] c);
        return (c > 32'd15) ? 4'hF : c[3:0];
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered pointers and a separate occupancy count.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    always_comb begin
        full     = (count_q == CW'(DEPTH));
        empty    = (count_q == '0);
        count    = count_q;
        rdata    = mem_q[rd_ptr_q];
        pop_ok   = pop & ~empty;
        push_ok  = push & (~full | pop_ok);
        // Depth is a power of two, so pointer overflow is the wrap.
        wr_ptr_d = wr_ptr_q + AW'(push_ok);
        rd_ptr_d = rd_ptr_q + AW'(pop_ok);
        count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA stores feed a FIFO that a
// baud-timed serialiser drains onto tx; STATUS loads report FIFO/line state.
module mmio_uart_tx
    import mmio_uart_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR    = 64'h0000_0000_1000_0000,
    parameter int          CLKS_PER_BIT = 868,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] addr,
    input  logic [63:0] wdata,
    input  logic        wmem,
    input  logic [2:0]  funct3,
    output logic        hit,
    output logic [63:0] rdata,
    output logic        tx
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic [1:0]    state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          overflow_q, overflow_d;

    logic [3:0]    off;
    logic          push_req, status_wr, drop, pop, baud_end;
    logic [63:0]   status;
    logic [7:0]    fifo_rdata;
    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          unused_bus;

    assign unused_bus = ^{funct3, wdata[63:8]};

    // FIFO handshake: push is a request that the FIFO accepts when not full or
    // when pop is high the same cycle; pop is issued only by the serialiser and
    // only while the FIFO is non-empty, with fifo_rdata valid in that cycle.
    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_req),
        .pop   (pop),
        .wdata (wdata[7:0]),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        off       = addr[3:0];
        hit       = (addr[63:4] == BASE_ADDR[63:4]);
        push_req  = hit & wmem & (off == TXDATA_OFF);
        status_wr = hit & wmem & (off == STATUS_OFF);
        baud_end  = (baud_q == BW'(CLKS_PER_BIT - 1));
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_rdata;
                    baud_d  = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    // Chaining straight into START keeps back-to-back frames gapless.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_rdata;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_comb begin
        drop       = push_req & fifo_full & ~pop;
        overflow_d = status_wr ? 1'b0 : (overflow_q | drop);

        status                          = '0;
        status[ST_FULL]                 = fifo_full;
        status[ST_EMPTY]                = fifo_empty;
        status[ST_BUSY]                 = (state_q != S_IDLE);
        status[ST_OVF]                  = overflow_q;
        status[ST_CNT_LO +: 4]          = sat_count4(32'(fifo_count));
        rdata = (hit && off == STATUS_OFF) ? status : 64'd0;
        tx    = tx_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Randomised and directed bench for mmio_uart_tx against a byte-queue /
// line-waveform reference model.
module tb_mmio_uart_tx;

    localparam logic [63:0] BASE  = 64'h0000_0000_1000_0000;
    localparam int          CPB   = 4;
    localparam int          DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] addr = '0;
    logic [63:0] wdata = '0;
    logic        wmem = 1'b0;
    logic [2:0]  funct3 = '0;
    logic        hit;
    logic [63:0] rdata;
    logic        tx;

    int total = 0;
    int bad   = 0;

    // Reference model: pending bytes, sticky overflow, and the remaining line
    // waveform (one entry per clock) of the frame being sent.
    logic [7:0] m_q[$];
    logic [0:0] exp_q[$];
    logic       m_ovf = 1'b0;

    always #5 clk = ~clk;

    mmio_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk    (clk),
        .reset  (reset),
        .addr   (addr),
        .wdata  (wdata),
        .wmem   (wmem),
        .funct3 (funct3),
        .hit    (hit),
        .rdata  (rdata),
        .tx     (tx)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic m_hit(input logic [63:0] a);
        return a[63:4] == BASE[63:4];
    endfunction

    function automatic logic [63:0] m_status();
        logic [63:0] s;
        int n;
        n    = m_q.size();
        s    = '0;
        s[0] = (n == DEPTH);
        s[1] = (n == 0);
        s[2] = (exp_q.size() != 0);
        s[3] = m_ovf;
        s[7:4] = (n > 15) ? 4'hF : 4'(n);
        return s;
    endfunction

    function automatic logic [63:0] m_rdata(input logic [63:0] a);
        return (m_hit(a) && a[3:0] == 4'h8) ? m_status() : 64'd0;
    endfunction

    // One clock: drive, check combinational outputs and tx at negedge, then
    // advance the model at the posedge.
    task automatic step(input logic rst, input logic [63:0] a, input logic [63:0] d, input logic we);
        logic       popping;
        logic       is_push;
        logic       is_clr;
        int         n_pre;
        logic [7:0] b;
        logic [0:0] bv;
        reset  = rst;
        addr   = a;
        wdata  = d;
        wmem   = we;
        funct3 = 3'($urandom_range(0, 7));
        @(negedge clk);
        chk("hit", 64'(hit), 64'(m_hit(a)));
        chk("rdata", rdata, m_rdata(a));
        if (exp_q.size() != 0) chk("tx", 64'(tx), 64'(exp_q.pop_front()));
        else chk("tx_idle", 64'(tx), 64'd1);
        @(posedge clk);
        if (rst) begin
            m_q.delete();
            exp_q.delete();
            m_ovf = 1'b0;
        end else begin
            n_pre   = m_q.size();
            is_push = we && m_hit(a) && a[3:0] == 4'h0;
            is_clr  = we && m_hit(a) && a[3:0] == 4'h8;
            popping = (exp_q.size() == 0) && (n_pre != 0);
            if (popping) begin
                b = m_q.pop_front();
                for (int j = 0; j < 10; j++) begin
                    bv = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : b[j-1];
                    for (int k = 0; k < CPB; k++) exp_q.push_back(bv);
                end
            end
            if (is_push) begin
                if (n_pre < DEPTH || popping) m_q.push_back(d[7:0]);
                else m_ovf = 1'b1;
            end
            if (is_clr) m_ovf = 1'b0;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, BASE + 64'h8, 64'd0, 1'b0);
    endtask

    initial begin
        logic [39:0] wave;
        logic [39:0] exp_wave;
        logic [9:0]  fbits;
        int          r;
        logic [63:0] a;

        // Reset and idle line
        for (int i = 0; i < 3; i++) step(1'b1, BASE + 64'h8, 64'd0, 1'b0);
        idle(50);
        chk("idle_status", rdata, 64'h2);
        chk("idle_tx", 64'(tx), 64'd1);
        addr = BASE + 64'h8;
        #1 chk("hit_in", 64'(hit), 64'd1);
        addr = BASE + 64'h10;
        #1 chk("hit_out", 64'(hit), 64'd0);

        // Single frame of 0xA5, captured and compared against a literal pattern
        step(1'b0, BASE, 64'hFFFF_FFA5, 1'b1);
        for (int i = 0; i < 40; i++) begin
            step(1'b0, BASE + 64'h8, 64'd0, 1'b0);
            wave[i] = tx;
        end
        fbits = {1'b1, 8'hA5, 1'b0};
        for (int i = 0; i < 40; i++) exp_wave[i] = fbits[i / CPB];
        chk("a5_frame", 64'(wave), 64'(exp_wave));
        idle(5);

        // Three back-to-back bytes
        for (int i = 0; i < 3; i++) step(1'b0, BASE, 64'($urandom), 1'b1);
        idle(125);
        chk("b2b_status", rdata, 64'h2);

        // Overflow: ten stores in consecutive cycles
        for (int i = 0; i < 10; i++) step(1'b0, BASE, 64'($urandom), 1'b1);
        addr = BASE + 64'h8;
        wmem = 1'b0;
        #1 chk("status_8d", rdata, 64'h8D);
        step(1'b0, BASE + 64'h8, 64'h0, 1'b1);
        #1 chk("ovf_clear", 64'(rdata[3]), 64'd0);
        idle(400);

        // Reset during DATA bit 3
        step(1'b0, BASE, 64'($urandom), 1'b1);
        for (int i = 0; i < 18; i++) step(1'b0, BASE + 64'h8, 64'd0, 1'b0);
        step(1'b1, BASE + 64'h8, 64'd0, 1'b0);
        chk("rst_tx", 64'(tx), 64'd1);
        addr = BASE + 64'h8;
        #1 chk("rst_status", rdata, 64'h2);
        idle(60);

        // Stores outside TXDATA do not enqueue
        step(1'b0, BASE + 64'h4, 64'h55, 1'b1);
        step(1'b0, BASE + 64'h10, 64'h55, 1'b1);
        chk("stray_rdata", rdata, 64'd0);
        idle(10);
        chk("stray_status", rdata, 64'h2);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 99);
            if (r < 20)      step(1'b0, BASE, 64'({$urandom, $urandom}), 1'b1);
            else if (r < 24) step(1'b0, BASE + 64'h8, 64'($urandom), 1'b1);
            else if (r < 27) step(1'b0, BASE + 64'h4, 64'($urandom), 1'b1);
            else if (r < 29) step(1'b0, BASE + 64'h10, 64'($urandom), 1'b1);
            else if (r < 30) step(1'b1, BASE + 64'h8, 64'($urandom), 1'b1);
            else begin
                a = (r < 90) ? BASE + 64'h8 : {$urandom, $urandom};
                step(1'b0, a, 64'($urandom), 1'(r & 1));
            end
        end
        idle(500);
        chk("final_status", rdata, 64'h2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter peripheral that answers data-memory accesses issued by the core's memory stage. Stores to its data register enqueue bytes into an internal FIFO; a serialiser drains the FIFO onto a single 8N1 `tx` line. Loads from its status register return FIFO and line state. It sits beside the data memory mapper on the memory-stage bus and drives the board UART pin.

## Interface
- `BASE_ADDR`, 64'h0000_0000_1000_0000: peripheral base; must be 16-byte aligned.
- `CLKS_PER_BIT`, 868: clock cycles per UART bit (115200 baud at 100 MHz); minimum 2.
- `FIFO_DEPTH`, 8: TX FIFO entries; power of two, minimum 2.

Ports:
- `clk`  in  1: system clock, rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `addr`  in  64: memory-stage address (execution result in memory stage).
- `wdata`  in  64: memory-stage store data.
- `wmem`  in  1: memory write enable.
- `funct3`  in  3: access size code; ignored for decode, accepted for bus compatibility.
- `hit`  out  1: combinational; high when `addr` is inside the 16-byte window.
- `rdata`  out  64: combinational read data; zero when `hit` is low.
- `tx`  out  1: serial output, registered, idles high.

## Operation
- Decode: `hit` = (`addr[63:4]` == `BASE_ADDR[63:4]`). Offset `addr[3:0]`: 0x0 = TXDATA, 0x8 = STATUS; other offsets read 0 and ignore writes.
- TXDATA write (`hit` & `wmem` & offset 0x0): push `wdata[7:0]` regardless of `funct3`. If FIFO full and no pop this cycle, byte is dropped and sticky `overflow` sets. TXDATA reads 0.
- STATUS read: bit0 `full`, bit1 `empty`, bit2 `busy` (FSM not IDLE), bit3 `overflow`, bits[7:4] FIFO count (saturates at 15), remaining bits 0.
- STATUS write (any data): clears `overflow`. If a dropped push and a clear occur in the same cycle, clear wins.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: `tx`=1. If FIFO non-empty: pop into shift register, go START.
  - START: `tx`=0 for CLKS_PER_BIT cycles, go DATA with bit index 0.
  - DATA: `tx`=shift[0], LSB first; after CLKS_PER_BIT cycles shift right and increment index; after bit 7 go STOP.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles. At end: if FIFO non-empty, pop and go START directly (no idle cycle); otherwise IDLE.
- Simultaneous push and pop: both take effect; a push to a full FIFO succeeds when a pop occurs in the same cycle. Count unchanged.
- Pointers wrap modulo FIFO_DEPTH; count is separate, width clog2(FIFO_DEPTH)+1.

## Timing
- Reset values: `tx`=1, FSM=IDLE, FIFO empty (count 0), `overflow`=0, bit counter and baud counter 0. `hit`/`rdata` follow `addr` combinationally.
- Reset mid-frame: next edge returns to IDLE with `tx`=1; FIFO contents are discarded; the partial frame is truncated.
- Write at edge E0 → count=1 after E0; at E1 FSM pops, `tx` falls after E1.
- Frame length exactly 10×CLKS_PER_BIT cycles; back-to-back frames have no gap.
- `rdata` reflects register state before the current edge, so a load in the same cycle as a push sees the old count.

## Structure
- Package `mmio_uart_pkg`: offsets TXDATA_OFF=4'h0 and STATUS_OFF=4'h8, STATUS bit positions, FSM state enum.
- Sub-module `sync_fifo`, parameterised width/depth, push/pop/full/empty/count. Decode, status mux, and the baud/bit counters with the FSM stay in the top module.

## Test plan
- Reset, then idle 50 cycles → `tx`=1, STATUS read = 0x2 (empty), `hit`=1 at BASE_ADDR+8 and 0 at BASE_ADDR+16.
- CLKS_PER_BIT=4. Store 0xA5 to TXDATA (`wdata`=64'hFFFF_FFA5) → after 1 cycle `tx` low for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high for 4 cycles. Total 40 cycles.
- Store 3 bytes back-to-back → three contiguous 40-cycle frames with no idle gap. STATUS bit2 stays 1 throughout and reads 0x2 afterward.
- FIFO_DEPTH=8, CLKS_PER_BIT=4. Store 10 bytes in 10 consecutive cycles → 9 accepted (1 popped at once), 1 dropped. STATUS = 0x8D mid-stream (count 8, overflow, busy, full). Store to STATUS → overflow clears.
- Assert `reset` during DATA bit 3 → `tx`=1 next cycle, STATUS=0x2, no further frames.
- Store to BASE_ADDR+4 and to BASE_ADDR+16 → no enqueue, `tx` stays high, `rdata`=0.
